// File: rtl/ha2_task3_pkg.sv
// ha2_task3_pkg
// Shared types and constants for the ha2_task3 serial pattern detector.
//   state_t : FSM state, binary-encoded in 3 bits; the name gives the matched prefix
//             (S0 none, S1 "1", S2 "10", S3 "101", S4 "1011" detected)
//   PATTERN : detected bit pattern, first bit oldest
//   PAT_LEN : pattern length in bits
package ha2_task3_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  localparam logic [3:0]  PATTERN = 4'b1011;
  localparam int unsigned PAT_LEN = 4;

endpackage

// File: rtl/ha2_task3_if.sv
// ha2_task3_if
// Serial stream signals of the ha2_task3 pattern detector.
//   DIN  : serial data bit, driven by the stream source
//   DOUT : one-cycle detect flag, driven by the detector
// Modports:
//   master : stream source / monitor side (drives DIN, observes DOUT)
//   slave  : detector side (samples DIN, drives DOUT)
interface ha2_task3_if;

  logic DIN;
  logic DOUT;

  modport master (output DIN, input DOUT);
  modport slave  (input DIN, output DOUT);

endinterface

// File: rtl/ha2_task3_rst_sync.sv
// ha2_task3_rst_sync
// Two-flop reset synchroniser: assertion is asynchronous, release is aligned
// to CLK after two rising edges so downstream flops leave reset cleanly.
// Ports:
//   CLK     : system clock, rising-edge active
//   RST     : raw reset, asynchronous, active-low
//   rst_n_o : synchronised reset, active-low
module ha2_task3_rst_sync (
  input  logic CLK,
  input  logic RST,
  output logic rst_n_o
);

  logic [1:0] sync_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_n_o = sync_q[1];

endmodule

// File: rtl/ha2_task3.sv
// ha2_task3
// Serial bit-stream pattern detector. Samples DIN on every rising CLK edge and
// raises DOUT for one cycle when the last four sampled bits equal 1011
// (first bit oldest). Moore FSM, DOUT driven straight from a flop.
// Ports:
//   CLK : system clock, rising-edge active
//   RST : reset, asynchronous assert, active-low; release synchronised internally
//   bus : ha2_task3_if.slave (DIN in, DOUT out)
// Build option:
//   HA2_TASK3_OVERLAP_EN defined   -> overlapping detection (S4: 0->S2, 1->S1)
//   HA2_TASK3_OVERLAP_EN undefined -> non-overlapping      (S4: 0->S0, 1->S1)
module ha2_task3
  import ha2_task3_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  ha2_task3_if.slave    bus
);

  logic   rst_n;
  state_t state_q;
  state_t state_d;
  logic   dout_q;
  logic   dout_d;

  ha2_task3_rst_sync u_rst_sync (
    .CLK     (CLK),
    .RST     (RST),
    .rst_n_o (rst_n)
  );

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unreachable encodings fall back to S0
  always_comb begin
    state_d = S0;
    case (state_q)
      S0: state_d = bus.DIN ? S1 : S0;
      S1: state_d = bus.DIN ? S1 : S2;
      S2: state_d = bus.DIN ? S3 : S0;
      S3: state_d = bus.DIN ? S4 : S2;
`ifdef HA2_TASK3_OVERLAP_EN
      S4: state_d = bus.DIN ? S1 : S2;
`else
      S4: state_d = bus.DIN ? S1 : S0;
`endif
      default: state_d = S0;
    endcase
  end

  // Output logic: decoded from the next state so the flop below holds
  // DOUT=1 exactly while state_q is S4, with no DIN->DOUT path.
  always_comb begin
    dout_d = (state_d == S4);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign bus.DOUT = dout_q;

endmodule

// File: tb/tb_ha2_task3.sv
// tb_ha2_task3
// Self-checking bench for ha2_task3. Stimulus pushes the expected DOUT for each
// driven bit into a queue; a monitor pops one entry per sampling edge and
// compares DOUT at the following falling edge.
module tb_ha2_task3;
  import ha2_task3_pkg::*;

`ifdef HA2_TASK3_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ha2_task3_if u_if ();

  ha2_task3 dut (
    .CLK (clk),
    .RST (rst),
    .bus (u_if)
  );

  // Monitor: an entry queued before this edge belongs to the bit sampled here
  initial begin
    logic e;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        @(negedge clk);
        total++;
        if (u_if.DOUT !== e) begin
          bad++;
          $display("FAIL dout cyc=%0d got=%b exp=%b", cyc, u_if.DOUT, e);
        end
      end
    end
  end

  task automatic drive_bit(input logic d, input logic e, input int unsigned off);
    @(posedge clk);
    #off;
    u_if.DIN = d;
    exp_q.push_back(e);
  endtask

  // Vectors written MSB-first: bit n-1 is the first bit driven
  task automatic run_vec(input logic [15:0] din, input logic [15:0] ex, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      drive_bit(din[n-1-i], ex[n-1-i], 1);
    end
  endtask

  // Hold reset n cycles with DIN toggling, release, then cover the two
  // synchroniser cycles whose DIN samples must be ignored.
  task automatic apply_reset(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      u_if.DIN = i[0];
      exp_q.push_back(1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    u_if.DIN = 1'b1;
    exp_q.push_back(1'b0);
    @(posedge clk);
    #1;
    u_if.DIN = 1'b1;
    exp_q.push_back(1'b0);
  endtask

  initial begin
    logic [3:0]  hist;
    int unsigned cnt;
    logic        d;
    logic        m;

    rst = 1'b0;
    u_if.DIN = 1'b0;

    // Reset then 0000: DOUT stays low throughout
    apply_reset(3);
    run_vec(16'b0000, 16'b0000, 4);

    // Single match
    run_vec(16'b010110, 16'b000010, 6);
    run_vec(16'b0000, 16'b0000, 4);

    // Overlap sequence
    if (OVERLAP) run_vec(16'b1011011, 16'b0001001, 7);
    else         run_vec(16'b1011011, 16'b0001000, 7);
    run_vec(16'b0000, 16'b0000, 4);

    // Near-misses, final 1011 on edges 8..11
    run_vec(16'b10011101011, 16'b00000000001, 11);
    run_vec(16'b0000, 16'b0000, 4);

    // Reset mid-pattern discards the partial 101
    run_vec(16'b101, 16'b000, 3);
    apply_reset(1);
    run_vec(16'b1, 16'b0, 1);
    run_vec(16'b0000, 16'b0000, 4);

    // Asynchronous reset clears a live DOUT pulse without a clock edge
    run_vec(16'b1011, 16'b0001, 4);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (u_if.DOUT !== 1'b0) begin
      bad++;
      $display("FAIL async_rst got=%b exp=0", u_if.DOUT);
    end
    apply_reset(2);

    // Random soak against a shift-register reference model
    hist = '0;
    cnt  = 0;
    for (int unsigned i = 0; i < 128; i++) begin
      d    = 1'($urandom_range(0, 1));
      hist = {hist[2:0], d};
      if (cnt < PAT_LEN) cnt++;
      m = (cnt >= PAT_LEN) && (hist == PATTERN);
      if (m && !OVERLAP) cnt = 0;
      drive_bit(d, m, $urandom_range(1, 8));
    end
    drive_bit(1'b0, 1'b0, 1);

    repeat (3) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ha2_task3.md
# ha2_task3

Serial bit-stream pattern detector. Samples one bit of DIN on every rising CLK edge and asserts DOUT for exactly one cycle when the last four sampled bits equal 1011, first bit oldest. It is a standalone Moore FSM leaf block used as a simple stream monitor and has no handshake.

## Interface
- Parameters: none. The pattern is fixed at 4'b1011 and lives in the package.
- CLK  input  1  system clock; rising-edge active.
- RST  input  1  reset; asynchronous, active-low.
- DIN  input  1  serial data bit; sampled on every CLK rising edge.
- DOUT  output  1  detect flag; registered Moore output.

## Operation
- Five-state Moore FSM. State name gives the matched prefix:
  - S0 = none
  - S1 = "1"
  - S2 = "10"
  - S3 = "101"
  - S4 = "1011", pattern detected
- Transitions, written as DIN=0 / DIN=1:
  - S0 -> S0 / S1
  - S1 -> S2 / S1
  - S2 -> S0 / S3
  - S3 -> S2 / S4
  - S4 -> S2 / S1 (overlap build; see Configuration)
- DOUT = 1 only while the state is S4; otherwise DOUT = 0.
- DOUT comes directly from a flop: the state register or a dedicated output register. No combinational path from DIN to DOUT.
- Any unreachable state encoding goes to S0 on the next edge with DOUT = 0.
- Reset forces state S0 and DOUT = 0.
  - Takes effect immediately, independent of CLK.
  - Asserting RST mid-pattern discards the partial match.

## Timing
- DIN must meet setup/hold around the CLK rising edge. It may change anywhere else in the period.
- Latency: DOUT rises at the rising edge that samples the final '1' of the pattern and holds for one full cycle.
  - DOUT is visible after the clock-to-Q delay following that edge.
  - DOUT falls at the next edge unless that edge completes a new match, which cannot happen on the immediately following bit.
- Minimum spacing between two DOUT pulses:
  - 3 cycles with overlap enabled (1011011).
  - 4 cycles with overlap disabled.
- Release of RST (rising edge) is synchronised internally with a 2-flop synchroniser. The first DIN sample counts from the first CLK edge after release completes.
- While RST = 0: DOUT = 0 and DIN is ignored.

## Configuration
- Macro: HA2_TASK3_OVERLAP_EN.
- Defined: overlapping detection. From S4, DIN=0 -> S2 and DIN=1 -> S1. A suffix of a match may begin the next match.
- Undefined: non-overlapping detection. From S4, DIN=0 -> S0 and DIN=1 -> S1. After a match, detection restarts from scratch.
- All other transitions, outputs and reset behaviour are identical in both builds.

## Structure
- Package ha2_task3_pkg holds:
  - typedef enum state_t {S0..S4}, binary-encoded in 3 bits
  - localparam PATTERN = 4'b1011
  - localparam PAT_LEN = 4
- Single module with three parts:
  - state register with async reset
  - combinational next-state case
  - registered output
- One optional sub-module: ha2_task3_rst_sync, the 2-flop reset-release synchroniser.
- No other hierarchy.

## Test plan
- Reset: hold RST=0 for 3 cycles with DIN toggling, then release. Required: DOUT=0 throughout reset, and state S0 (checked via DOUT=0 on the following 0000 input).
- Single match: DIN = 0,1,0,1,1,0 on successive edges. Required: DOUT=1 only in the cycle after the 5th edge; DOUT=0 in all others.
- Overlap (macro defined): DIN = 1,0,1,1,0,1,1. Required: DOUT pulses after edge 4 and after edge 7. With the macro undefined, the same input must give only the pulse after edge 4.
- Near-misses: DIN = 1,0,0,1,1,1,0,1,0,1,1. Required:
  - no pulse through edge 10
  - pulse after edge 11 (the 1011 on edges 8–11)
  - the 111 run correctly holds S1
- Reset mid-pattern: DIN = 1,0,1, then RST=0 for one cycle, release, then DIN = 1. Required: no pulse, because the partial match was discarded.
- Random soak: 128 random DIN bits with data changes at random offsets inside the cycle. Required: DOUT matches a reference model (4-bit shift-register compare, overlap per macro) on every cycle.
